// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Conditions a raw, asynchronous level before it reaches downstream gating
// logic. The raw input is first brought into the clk domain through a
// multi-flop synchroniser. A small qualifier then requires the synchronised
// level to differ from the current output for FILTER_CYCLES consecutive
// enabled cycles before the output follows it. Shorter excursions are
// discarded. Every instance is fully independent.
//
// Parameters:
//   SYNC_STAGES   number of synchroniser flops (2..4)
//   FILTER_CYCLES consecutive cycles a new level must persist (1..255)
//   RESET_VALUE   reset level of the synchroniser chain and of out_a
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous, active-low reset
//   in_a      raw asynchronous input level
//   in_en     filter enable; 0 freezes the qualifier and out_a
//   out_a     debounced level
//   out_rise  one-cycle pulse in the cycle out_a first shows 1
//   out_fall  one-cycle pulse in the cycle out_a first shows 0
//   out_busy  high while a level change is being qualified
//
// Qualifier states:
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | synchronised level matches out_a, nothing pending
//   ST_COUNT | synchronised level differs from out_a, counting persistence
//
// Every output is driven directly by a flop, so there is no combinational
// path from any input to any output.
// -----------------------------------------------------------------------------
module input_debouncer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4,
    parameter bit          RESET_VALUE   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_a,
    input  logic in_en,
    output logic out_a,
    output logic out_rise,
    output logic out_fall,
    output logic out_busy
);

    // Counter only needs to reach FILTER_CYCLES-1. It never wraps because the
    // terminal compare always sends the FSM back to ST_IDLE first.
    localparam int unsigned CNT_W = ($clog2(FILTER_CYCLES) > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(FILTER_CYCLES - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Synchroniser. It runs whatever in_en is doing, so that on re-enable the
    // qualifier compares against an up-to-date level.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_a};
        end
    end

    assign sync_level = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Qualifier FSM: state register
    // -------------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= RESET_VALUE;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Qualifier FSM: next state and outputs. With in_en low every value holds
    // and the pulses drop, so counting resumes from the held count later.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (in_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (sync_level == level_q) begin
                        cnt_d = '0;
                    end else if (FILTER_CYCLES == 1) begin
                        // A single-cycle filter accepts the new level on first sight.
                        level_d = sync_level;
                        rise_d  = sync_level;
                        fall_d  = ~sync_level;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = ST_COUNT;
                    end
                end

                ST_COUNT: begin
                    if (sync_level == level_q) begin
                        // The level went back before it qualified, so treat it as a glitch.
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else if (cnt_q == CNT_TERM) begin
                        level_d = sync_level;
                        rise_d  = sync_level;
                        fall_d  = ~sync_level;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                default: begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_COUNT);
    end

    assign out_a    = level_q;
    assign out_rise = rise_q;
    assign out_fall = fall_q;
    assign out_busy = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
//
// Two instances: defaults (SYNC 2, FILTER 4) and a fast one (SYNC 3, FILTER 1).
// The reference model treats each instance as a pure delay line of
// SYNC_STAGES samples followed by a run-length rule. The output takes on the
// delayed level once that level has differed from the output for FILTER_CYCLES
// consecutive enabled edges. Disabled edges neither extend the run nor break
// it.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

    localparam int unsigned S0 = 2;
    localparam int unsigned F0 = 4;
    localparam int unsigned S1 = 3;
    localparam int unsigned F1 = 1;
    localparam bit          RV = 1'b0;

    logic clk;
    logic rst_n;
    logic in_a0, in_en0, out_a0, out_rise0, out_fall0, out_busy0;
    logic in_a1, in_en1, out_a1, out_rise1, out_fall1, out_busy1;

    int vectors     = 0;
    int miscompares = 0;

    input_debouncer #(.SYNC_STAGES(S0), .FILTER_CYCLES(F0), .RESET_VALUE(RV)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_a(in_a0), .in_en(in_en0),
        .out_a(out_a0), .out_rise(out_rise0), .out_fall(out_fall0), .out_busy(out_busy0)
    );

    input_debouncer #(.SYNC_STAGES(S1), .FILTER_CYCLES(F1), .RESET_VALUE(RV)) u_fast (
        .clk(clk), .rst_n(rst_n), .in_a(in_a1), .in_en(in_en1),
        .out_a(out_a1), .out_rise(out_rise1), .out_fall(out_fall1), .out_busy(out_busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    logic q0[$];
    logic q1[$];
    logic m_out[2];
    int   m_run[2];
    logic m_rise[2];
    logic m_fall[2];

    task automatic model_reset();
        q0.delete();
        q1.delete();
        repeat (S0) q0.push_back(RV);
        repeat (S1) q1.push_back(RV);
        for (int i = 0; i < 2; i++) begin
            m_out[i]  = RV;
            m_run[i]  = 0;
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
        end
    endtask

    task automatic model_step(int id, logic a, logic en);
        logic s;
        int   f;
        if (id == 0) begin
            s = q0[$];
            q0.push_front(a);
            void'(q0.pop_back());
            f = F0;
        end else begin
            s = q1[$];
            q1.push_front(a);
            void'(q1.pop_back());
            f = F1;
        end
        m_rise[id] = 1'b0;
        m_fall[id] = 1'b0;
        if (en) begin
            if (s != m_out[id]) begin
                m_run[id] = m_run[id] + 1;
                if (m_run[id] >= f) begin
                    m_out[id]  = s;
                    m_run[id]  = 0;
                    m_rise[id] = s;
                    m_fall[id] = ~s;
                end
            end else begin
                m_run[id] = 0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(string tag, logic obs, logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("d_out",   out_a0,    m_out[0]);
        chk("d_rise",  out_rise0, m_rise[0]);
        chk("d_fall",  out_fall0, m_fall[0]);
        chk("d_busy",  out_busy0, m_run[0] > 0);
        chk("f_out",   out_a1,    m_out[1]);
        chk("f_rise",  out_rise1, m_rise[1]);
        chk("f_fall",  out_fall1, m_fall[1]);
        chk("f_busy",  out_busy1, m_run[1] > 0);
    endtask

    // One rising edge: advance the model with the inputs the DUT sampled, then
    // compare just after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model_step(0, in_a0, in_en0);
            model_step(1, in_a1, in_en1);
        end
        #1;
        check_all();
    endtask

    int busy_cnt;
    int rise_cnt;
    int run0;
    int run1;

    initial begin
        rst_n  = 1'b0;
        in_a0  = 1'b1;
        in_a1  = 1'b1;
        in_en0 = 1'b1;
        in_en1 = 1'b1;
        model_reset();

        // ---- reset with in_a held high ----
        repeat (3) tick();
        chk("rst_out_low", out_a0, RV);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rst_fast_e3", out_a1, 1'b0);
        tick();
        chk("rst_fast_e4", out_a1, 1'b1);
        chk("rst_fast_rise", out_rise1, 1'b1);
        tick();
        chk("rst_e5_out", out_a0, 1'b0);
        tick();
        chk("rst_e6_out", out_a0, 1'b1);
        chk("rst_e6_rise", out_rise0, 1'b1);
        tick();
        chk("rst_e7_rise", out_rise0, 1'b0);
        repeat (2) tick();

        // ---- fall with steady low input ----
        in_a0 = 1'b0;
        repeat (2) tick();
        chk("fall_e2_busy", out_busy0, 1'b0);
        tick();
        chk("fall_e3_busy", out_busy0, 1'b1);
        repeat (2) tick();
        chk("fall_e5_busy", out_busy0, 1'b1);
        chk("fall_e5_out", out_a0, 1'b1);
        tick();
        chk("fall_e6_out", out_a0, 1'b0);
        chk("fall_e6_fall", out_fall0, 1'b1);
        chk("fall_e6_busy", out_busy0, 1'b0);
        tick();
        chk("fall_e7_fall", out_fall0, 1'b0);
        repeat (2) tick();

        // ---- three-cycle glitch ----
        busy_cnt = 0;
        rise_cnt = 0;
        in_a0 = 1'b1;
        repeat (3) begin
            tick();
            busy_cnt += int'(out_busy0);
            rise_cnt += int'(out_rise0);
        end
        in_a0 = 1'b0;
        repeat (10) begin
            tick();
            busy_cnt += int'(out_busy0);
            rise_cnt += int'(out_rise0);
        end
        chk("glitch_out", out_a0, 1'b0);
        chk("glitch_busy3", busy_cnt == 3, 1'b1);
        chk("glitch_norise", rise_cnt == 0, 1'b1);

        // ---- enable freeze at counter = 2 ----
        in_a0 = 1'b1;
        repeat (4) tick();
        chk("frz_busy_pre", out_busy0, 1'b1);
        in_en0 = 1'b0;
        repeat (5) begin
            tick();
            chk("frz_out", out_a0, 1'b0);
            chk("frz_rise", out_rise0, 1'b0);
            chk("frz_busy", out_busy0, 1'b1);
        end
        in_en0 = 1'b1;
        tick();
        chk("frz_re1_out", out_a0, 1'b0);
        tick();
        chk("frz_re2_out", out_a0, 1'b1);
        chk("frz_re2_rise", out_rise0, 1'b1);
        repeat (2) tick();

        // ---- reset while counter = 3 ----
        in_a0 = 1'b0;
        repeat (5) tick();
        chk("mid_busy_pre", out_busy0, 1'b1);
        chk("mid_out_pre", out_a0, 1'b1);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_out_async", out_a0, RV);
        chk("mid_busy_async", out_busy0, 1'b0);
        chk("mid_fall_async", out_fall0, 1'b0);
        chk("mid_rise_async", out_rise0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) tick();

        // ---- fast instance: toggle every 10 cycles ----
        for (int t = 0; t < 6; t++) begin
            in_a1 = ~in_a1;
            repeat (3) tick();
            chk("tog_e3_old", out_a1, ~in_a1);
            tick();
            chk("tog_e4_new", out_a1, in_a1);
            chk("tog_pulse", in_a1 ? out_rise1 : out_fall1, 1'b1);
            repeat (6) tick();
        end

        // ---- randomized bursts on both instances ----
        run0 = 0;
        run1 = 0;
        for (int c = 0; c < 1500; c++) begin
            if (run0 == 0) begin
                in_a0 = logic'($urandom_range(0, 1));
                run0  = $urandom_range(1, 8);
            end
            if (run1 == 0) begin
                in_a1 = logic'($urandom_range(0, 1));
                run1  = $urandom_range(1, 4);
            end
            in_en0 = ($urandom_range(0, 9) != 0);
            in_en1 = ($urandom_range(0, 9) != 0);
            run0--;
            run1--;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Conditioning stage that sits directly upstream of the and_gate. It produces the clean level that drives the gate's inputs.
- Synchronises an asynchronous raw input into clk and rejects glitches shorter than FILTER_CYCLES.
- Outputs a filtered level plus single-cycle rise/fall pulses.
- Multiple instances may feed one gate; each instance is independent.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops (legal range 2..4).
- FILTER_CYCLES, 4, consecutive synchronised cycles of a new level required before out_a follows it (legal range 1..255).
- RESET_VALUE, 0, reset level of the synchroniser chain and of out_a.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_a  input  1  raw, asynchronous input level.
- in_en  input  1  filter enable; when 0, filter state and out_a are frozen.
- out_a  output  1  debounced level.
- out_rise  output  1  one-cycle pulse on the cycle out_a goes 0->1.
- out_fall  output  1  one-cycle pulse on the cycle out_a goes 1->0.
- out_busy  output  1  high while a level change is being qualified (FSM in COUNT).

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n low: all sync flops = RESET_VALUE, out_a = RESET_VALUE, counter = 0, FSM = IDLE, out_rise = out_fall = out_busy = 0.
  - Deassertion takes effect at the next rising edge.
  - Reset asserted mid-qualification aborts it immediately; no pulse is emitted.
- Synchroniser:
  - in_a passes through SYNC_STAGES flops; s = last stage.
  - The chain runs regardless of in_en.
- Counter:
  - Width = max(1, clog2(FILTER_CYCLES)).
  - Saturates naturally because of the terminal compare; never wraps.
- FSM, evaluated every edge when in_en = 1:
  - IDLE:
    - s == out_a: stay, counter = 0.
    - s != out_a and FILTER_CYCLES == 1: flip out_a <= s, pulse, stay IDLE.
    - s != out_a and FILTER_CYCLES > 1: counter = 1, go to COUNT.
  - COUNT:
    - s == out_a: glitch rejected; counter = 0, go to IDLE, no pulse.
    - s != out_a and counter == FILTER_CYCLES-1: out_a <= s, counter = 0, go to IDLE, assert out_rise or out_fall for exactly this one registered cycle.
    - Otherwise: counter++.
- Latency: a stable in_a change is reflected on out_a exactly SYNC_STAGES + FILTER_CYCLES rising edges after it (edge 1 = first edge sampling the new level). With defaults this is 6 edges.
- Pulses:
  - Registered; high during the same cycle out_a first shows the new value.
  - out_rise and out_fall are never high simultaneously.
  - Both are 0 in every other cycle.
- out_busy = (FSM == COUNT); registered.
- in_en = 0:
  - FSM, counter and out_a hold their values.
  - out_rise = out_fall = 0.
  - out_busy holds its current value.
  - On re-enable, counting resumes from the held counter against the current s.
- Simultaneous events: a terminal count and s returning to out_a in the same cycle cannot both occur; the compare uses the current s only.
- No combinational path from any input to any output.

Test Plan:
- Reset:
  - Setup: RESET_VALUE = 0, in_a = 1 held during reset.
  - Required: out_a = 0 while rst_n = 0, then out_a = 1 exactly at edge 6 after release, with out_rise high for that single cycle.
- Glitch rejection:
  - Setup: defaults; in_a pulses high for 3 cycles, then returns low.
  - Required: out_a stays 0; out_rise never asserts; out_busy high for 3 cycles.
- Fall:
  - Setup: out_a = 1; drive in_a = 0 steady.
  - Required: out_a = 0 at edge 6; out_fall high exactly 1 cycle; out_busy high during edges 3..5.
- FILTER_CYCLES = 1, SYNC_STAGES = 3:
  - Setup: toggle in_a every 10 cycles.
  - Required: out_a follows with 4-edge latency; one pulse per toggle.
- Enable freeze:
  - Setup: defaults; in_a rises, in_en = 0 for 5 cycles once counter = 2, then in_en = 1.
  - Required: out_a rises 2 edges after re-enable; no pulse while disabled.
- Mid-operation reset:
  - Setup: assert rst_n low while counter = 3.
  - Required: out_a = RESET_VALUE and out_busy = 0 immediately (asynchronous); no pulse emitted.
